// File: rtl/insdec_mt_if.sv
// rtl/insdec_mt_if.sv - fetch-side and execute-side handshake bundle for insdec_mt
interface insdec_mt_if #(
   parameter int XLEN  = 32,
   parameter int TRD_W = 3,
   parameter int REG_W = 5,
   parameter int IMM_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [XLEN-1:0]  ins;
   logic [XLEN-1:0]  pc;
   logic [TRD_W-1:0] trd;

   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_data_a;
   logic [XLEN-1:0]  out_data_b;
   logic [XLEN-1:0]  out_pc;
   logic [XLEN-1:0]  out_ins;
   logic [TRD_W-1:0] out_trd;
   logic [TRD_W-1:0] out_new_trd;
   logic [REG_W-1:0] out_rd_a;
   logic [REG_W-1:0] out_rd_b;
   logic [REG_W-1:0] out_wr;
   logic [IMM_W-1:0] out_imm;
   logic             out_wr_en;
   logic             out_wb_sel;
   logic             out_i_type;
   logic             out_init;
   logic [2:0]       out_alu_op;
   logic [1:0]       out_mem_ctrl;
   logic [1:0]       out_trd_ctrl;
   logic [3:0]       out_jmp_con;

   modport master (
      output in_valid, ins, pc, trd, out_ready,
      input  in_ready, out_valid, out_data_a, out_data_b, out_pc, out_ins, out_trd,
             out_new_trd, out_rd_a, out_rd_b, out_wr, out_imm, out_wr_en, out_wb_sel,
             out_i_type, out_init, out_alu_op, out_mem_ctrl, out_trd_ctrl, out_jmp_con
   );

   modport slave (
      input  in_valid, ins, pc, trd, out_ready,
      output in_ready, out_valid, out_data_a, out_data_b, out_pc, out_ins, out_trd,
             out_new_trd, out_rd_a, out_rd_b, out_wr, out_imm, out_wr_en, out_wb_sel,
             out_i_type, out_init, out_alu_op, out_mem_ctrl, out_trd_ctrl, out_jmp_con
   );
endinterface

// File: rtl/insdec_mt.sv
// rtl/insdec_mt.sv - multithreaded decode/register stage with WB bypass, scoreboard and flush
// Instruction word: [31:28] opcode, [27:23] wr, [22:18] rd_a, [17:13] rd_b, [15:0] imm.
module insdec_mt #(
   parameter int NUM_TRD = 8,
   parameter int XLEN    = 32,
   parameter int NREG    = 32,
   parameter int IMM_W   = 16,
   parameter int TRD_W   = $clog2(NUM_TRD),
   parameter int REG_W   = $clog2(NREG)
) (
   input  logic               clk,
   input  logic               rst_n,
   insdec_mt_if.slave         bus,
   input  logic [TRD_W-1:0]   new_trd_id_i,
   input  logic [NUM_TRD-1:0] flush_mask_i,
   input  logic               wb_en_i,
   input  logic [TRD_W-1:0]   wb_trd_i,
   input  logic [REG_W-1:0]   wb_reg_i,
   input  logic [XLEN-1:0]    wb_data_i,
   input  logic               sq_en_i,
   input  logic [TRD_W-1:0]   sq_trd_i,
   input  logic [REG_W-1:0]   sq_reg_i,
   output logic               exp_jmp_o,
   output logic               exp_return_o,
   output logic               invalid_op_o,
   output logic               hazard_o
);
   localparam logic [3:0] OP_ALU_R = 4'd0;
   localparam logic [3:0] OP_ALU_I = 4'd1;
   localparam logic [3:0] OP_LOAD  = 4'd2;
   localparam logic [3:0] OP_STORE = 4'd3;
   localparam logic [3:0] OP_JMP   = 4'd4;
   localparam logic [3:0] OP_RET   = 4'd5;
   localparam logic [3:0] OP_INIT  = 4'd6;

   typedef struct packed {
      logic [XLEN-1:0]  data_a;
      logic [XLEN-1:0]  data_b;
      logic [XLEN-1:0]  pc;
      logic [XLEN-1:0]  ins;
      logic [TRD_W-1:0] trd;
      logic [TRD_W-1:0] new_trd;
      logic [REG_W-1:0] rd_a;
      logic [REG_W-1:0] rd_b;
      logic [REG_W-1:0] wr;
      logic [IMM_W-1:0] imm;
      logic             wr_en;
      logic             wb_sel;
      logic             i_type;
      logic             init;
      logic [2:0]       alu_op;
      logic [1:0]       mem_ctrl;
      logic [1:0]       trd_ctrl;
      logic [3:0]       jmp_con;
   } slot_t;

   logic [3:0]       opcode;
   logic [REG_W-1:0] dec_wr, dec_rd_a, dec_rd_b;
   logic             dec_wr_en, dec_wb_sel, dec_i_type, dec_init, use_a, use_b;
   logic             dec_jmp, dec_ret, dec_inv;
   logic [2:0]       dec_alu_op;
   logic [1:0]       dec_mem_ctrl, dec_trd_ctrl;
   logic [3:0]       dec_jmp_con;

   logic [XLEN-1:0]                 rf_q [NUM_TRD][NREG];
   logic [NUM_TRD-1:0][NREG-1:0]    sb_q, sb_d;
   slot_t                           slot_q, slot_d;
   logic                            out_valid_q, out_valid_d;

   logic            wb_hit_a, wb_hit_b, pend_a, pend_b, hazard;
   logic            in_ready, accept, flush_hit, init_acc, wb_wr;
   logic [XLEN-1:0] rd_data_a, rd_data_b;

   assign opcode   = bus.ins[XLEN-1 -: 4];
   assign dec_wr   = bus.ins[XLEN-5 -: REG_W];
   assign dec_rd_a = bus.ins[XLEN-5-REG_W -: REG_W];
   assign dec_rd_b = bus.ins[XLEN-5-2*REG_W -: REG_W];

   always_comb begin
      dec_wr_en    = 1'b0;
      dec_wb_sel   = 1'b0;
      dec_i_type   = 1'b0;
      dec_init     = 1'b0;
      use_a        = 1'b0;
      use_b        = 1'b0;
      dec_jmp      = 1'b0;
      dec_ret      = 1'b0;
      dec_inv      = 1'b0;
      dec_alu_op   = 3'd0;
      dec_mem_ctrl = 2'd0;
      dec_trd_ctrl = 2'd0;
      dec_jmp_con  = 4'd0;
      case (opcode)
         OP_ALU_R: begin
            dec_wr_en  = 1'b1;
            use_a      = 1'b1;
            use_b      = 1'b1;
            dec_alu_op = bus.ins[2:0];
         end
         OP_ALU_I: begin
            dec_wr_en  = 1'b1;
            dec_i_type = 1'b1;
            use_a      = 1'b1;
         end
         OP_LOAD: begin
            dec_wr_en    = 1'b1;
            dec_wb_sel   = 1'b1;
            dec_i_type   = 1'b1;
            dec_mem_ctrl = 2'b01;
            use_a        = 1'b1;
         end
         OP_STORE: begin
            dec_mem_ctrl = 2'b10;
            use_a        = 1'b1;
            use_b        = 1'b1;
         end
         OP_JMP: begin
            dec_jmp     = 1'b1;
            dec_jmp_con = bus.ins[3:0];
            use_a       = 1'b1;
            use_b       = 1'b1;
         end
         OP_RET: begin
            dec_ret      = 1'b1;
            dec_trd_ctrl = 2'b10;
         end
         OP_INIT: begin
            dec_init     = 1'b1;
            dec_trd_ctrl = 2'b01;
         end
         default: dec_inv = 1'b1;
      endcase
   end

   assign exp_jmp_o    = dec_jmp;
   assign exp_return_o = dec_ret;
   assign invalid_op_o = dec_inv;

   // A same-cycle writeback both forwards its data and resolves the pending source.
   assign wb_hit_a = wb_en_i && (wb_trd_i == bus.trd) && (wb_reg_i == dec_rd_a) && (wb_reg_i != '0);
   assign wb_hit_b = wb_en_i && (wb_trd_i == bus.trd) && (wb_reg_i == dec_rd_b) && (wb_reg_i != '0);

   assign rd_data_a = (dec_rd_a == '0) ? '0 : (wb_hit_a ? wb_data_i : rf_q[bus.trd][dec_rd_a]);
   assign rd_data_b = (dec_rd_b == '0) ? '0 : (wb_hit_b ? wb_data_i : rf_q[bus.trd][dec_rd_b]);

   assign pend_a    = use_a && sb_q[bus.trd][dec_rd_a] && !wb_hit_a;
   assign pend_b    = use_b && sb_q[bus.trd][dec_rd_b] && !wb_hit_b;
   assign hazard    = bus.in_valid && (pend_a || pend_b);
   assign hazard_o  = hazard;

   assign in_ready     = !hazard && (!out_valid_q || bus.out_ready) && !flush_mask_i[bus.trd];
   assign bus.in_ready = in_ready;
   assign accept       = bus.in_valid && in_ready;
   assign flush_hit    = out_valid_q && flush_mask_i[slot_q.trd];
   assign init_acc     = accept && dec_init;
   assign wb_wr        = wb_en_i && (wb_reg_i != '0) && !(init_acc && (wb_trd_i == new_trd_id_i));

   // Clears first, set last: a new writer to the same (trd, reg) stays pending.
   always_comb begin
      sb_d = sb_q;
      if (wb_en_i)
         sb_d[wb_trd_i][wb_reg_i] = 1'b0;
      if (sq_en_i)
         sb_d[sq_trd_i][sq_reg_i] = 1'b0;
      if (flush_hit && slot_q.wr_en)
         sb_d[slot_q.trd][slot_q.wr] = 1'b0;
      if (init_acc)
         sb_d[new_trd_id_i] = '0;
      if (accept && dec_wr_en && (dec_wr != '0))
         sb_d[bus.trd][dec_wr] = 1'b1;
   end

   always_comb begin
      slot_d      = slot_q;
      out_valid_d = out_valid_q;
      if (accept) begin
         out_valid_d     = 1'b1;
         slot_d.data_a   = rd_data_a;
         slot_d.data_b   = rd_data_b;
         slot_d.pc       = bus.pc;
         slot_d.ins      = bus.ins;
         slot_d.trd      = bus.trd;
         slot_d.new_trd  = dec_init ? new_trd_id_i : '0;
         slot_d.rd_a     = dec_rd_a;
         slot_d.rd_b     = dec_rd_b;
         slot_d.wr       = dec_wr;
         slot_d.imm      = bus.ins[IMM_W-1:0];
         slot_d.wr_en    = dec_wr_en;
         slot_d.wb_sel   = dec_wb_sel;
         slot_d.i_type   = dec_i_type;
         slot_d.init     = dec_init;
         slot_d.alu_op   = dec_alu_op;
         slot_d.mem_ctrl = dec_mem_ctrl;
         slot_d.trd_ctrl = dec_trd_ctrl;
         slot_d.jmp_con  = dec_jmp_con;
      end else if (out_valid_q && (bus.out_ready || flush_hit)) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         slot_q      <= '0;
         sb_q        <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         slot_q      <= slot_d;
         sb_q        <= sb_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int t = 0; t < NUM_TRD; t++)
            for (int r = 0; r < NREG; r++)
               rf_q[t][r] <= '0;
      end else begin
         if (init_acc)
            for (int r = 0; r < NREG; r++)
               rf_q[new_trd_id_i][r] <= '0;
         if (wb_wr)
            rf_q[wb_trd_i][wb_reg_i] <= wb_data_i;
      end
   end

   assign bus.out_valid    = out_valid_q;
   assign bus.out_data_a   = slot_q.data_a;
   assign bus.out_data_b   = slot_q.data_b;
   assign bus.out_pc       = slot_q.pc;
   assign bus.out_ins      = slot_q.ins;
   assign bus.out_trd      = slot_q.trd;
   assign bus.out_new_trd  = slot_q.new_trd;
   assign bus.out_rd_a     = slot_q.rd_a;
   assign bus.out_rd_b     = slot_q.rd_b;
   assign bus.out_wr       = slot_q.wr;
   assign bus.out_imm      = slot_q.imm;
   assign bus.out_wr_en    = slot_q.wr_en;
   assign bus.out_wb_sel   = slot_q.wb_sel;
   assign bus.out_i_type   = slot_q.i_type;
   assign bus.out_init     = slot_q.init;
   assign bus.out_alu_op   = slot_q.alu_op;
   assign bus.out_mem_ctrl = slot_q.mem_ctrl;
   assign bus.out_trd_ctrl = slot_q.trd_ctrl;
   assign bus.out_jmp_con  = slot_q.jmp_con;
endmodule

// File: tb/tb_insdec_mt.sv
// tb/tb_insdec_mt.sv - directed bench for insdec_mt with a per-cycle reference model
module tb_insdec_mt;
   localparam int NUM_TRD = 8;
   localparam int XLEN    = 32;
   localparam int NREG    = 32;
   localparam int IMM_W   = 16;
   localparam int TRD_W   = 3;
   localparam int REG_W   = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   insdec_mt_if #(.XLEN(XLEN), .TRD_W(TRD_W), .REG_W(REG_W), .IMM_W(IMM_W)) bus ();

   logic [TRD_W-1:0]   new_trd_id;
   logic [NUM_TRD-1:0] flush_mask;
   logic               wb_en;
   logic [TRD_W-1:0]   wb_trd;
   logic [REG_W-1:0]   wb_reg;
   logic [XLEN-1:0]    wb_data;
   logic               sq_en;
   logic [TRD_W-1:0]   sq_trd;
   logic [REG_W-1:0]   sq_reg;
   logic               exp_jmp, exp_return, invalid_op, hazard;

   insdec_mt #(.NUM_TRD(NUM_TRD), .XLEN(XLEN), .NREG(NREG), .IMM_W(IMM_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .new_trd_id_i (new_trd_id),
      .flush_mask_i (flush_mask),
      .wb_en_i      (wb_en),
      .wb_trd_i     (wb_trd),
      .wb_reg_i     (wb_reg),
      .wb_data_i    (wb_data),
      .sq_en_i      (sq_en),
      .sq_trd_i     (sq_trd),
      .sq_reg_i     (sq_reg),
      .exp_jmp_o    (exp_jmp),
      .exp_return_o (exp_return),
      .invalid_op_o (invalid_op),
      .hazard_o     (hazard)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Instruction-set meaning of each opcode, as a table of attributes.
   typedef struct packed {
      logic       wr_en, wb_sel, i_type, init, use_a, use_b, jmp, ret, inv;
      logic [2:0] alu;
      logic [1:0] mem, tctl;
      logic [3:0] jc;
   } dec_t;

   function automatic dec_t m_decode(input logic [31:0] ins);
      dec_t d = '0;
      case (ins[31:28])
         4'd0: begin d.wr_en = 1; d.use_a = 1; d.use_b = 1; d.alu = ins[2:0]; end
         4'd1: begin d.wr_en = 1; d.i_type = 1; d.use_a = 1; end
         4'd2: begin d.wr_en = 1; d.wb_sel = 1; d.i_type = 1; d.mem = 2'b01; d.use_a = 1; end
         4'd3: begin d.mem = 2'b10; d.use_a = 1; d.use_b = 1; end
         4'd4: begin d.jmp = 1; d.jc = ins[3:0]; d.use_a = 1; d.use_b = 1; end
         4'd5: begin d.ret = 1; d.tctl = 2'b10; end
         4'd6: begin d.init = 1; d.tctl = 2'b01; end
         default: d.inv = 1;
      endcase
      return d;
   endfunction

   function automatic logic [31:0] mk(input logic [3:0] op, input logic [4:0] wr,
                                      input logic [4:0] ra, input logic [4:0] rb,
                                      input logic [12:0] lo);
      return {op, wr, ra, rb, lo};
   endfunction

   // Model state: architectural registers, pending writers, and the expected slot.
   logic [31:0] m_rf [NUM_TRD][NREG];
   logic [31:0] m_sb [NUM_TRD];
   logic        m_valid;
   logic [31:0] m_a, m_b, m_pc, m_ins;
   logic [2:0]  m_trd, m_new;
   dec_t        m_dec;

   dec_t        c_d;
   logic        c_hit_a, c_hit_b, c_haz, c_rdy, c_acc, c_flushed;
   logic [31:0] c_va, c_vb;
   logic [4:0]  c_ra, c_rb, c_wr;
   logic [2:0]  c_t;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_valid = 1'b0;
         m_a = '0; m_b = '0; m_pc = '0; m_ins = '0; m_trd = '0; m_new = '0; m_dec = '0;
         for (int t = 0; t < NUM_TRD; t++) begin
            m_sb[t] = '0;
            for (int r = 0; r < NREG; r++) m_rf[t][r] = '0;
         end
      end else begin
         c_t  = bus.trd;
         c_d  = m_decode(bus.ins);
         c_wr = bus.ins[27:23];
         c_ra = bus.ins[22:18];
         c_rb = bus.ins[17:13];
         c_hit_a = wb_en && wb_trd == c_t && wb_reg == c_ra && wb_reg != 0;
         c_hit_b = wb_en && wb_trd == c_t && wb_reg == c_rb && wb_reg != 0;
         c_va = (c_ra == 0) ? 32'd0 : (c_hit_a ? wb_data : m_rf[c_t][c_ra]);
         c_vb = (c_rb == 0) ? 32'd0 : (c_hit_b ? wb_data : m_rf[c_t][c_rb]);
         c_haz = bus.in_valid && ((c_d.use_a && m_sb[c_t][c_ra] && !c_hit_a) ||
                                  (c_d.use_b && m_sb[c_t][c_rb] && !c_hit_b));
         c_rdy = !c_haz && (!m_valid || bus.out_ready) && !flush_mask[c_t];

         chk("in_ready", bus.in_ready, c_rdy);
         chk("hazard", hazard, c_haz);
         if (bus.in_valid)
            chk("decode_flags", {exp_jmp, exp_return, invalid_op}, {c_d.jmp, c_d.ret, c_d.inv});
         chk("out_valid", bus.out_valid, m_valid);
         if (m_valid) begin
            chk("out_data_a", bus.out_data_a, m_a);
            chk("out_data_b", bus.out_data_b, m_b);
            chk("out_pc_ins", {bus.out_pc, bus.out_ins}, {m_pc, m_ins});
            chk("out_trd", {bus.out_trd, bus.out_new_trd}, {m_trd, m_new});
            chk("out_ctrl",
                {bus.out_wr_en, bus.out_wb_sel, bus.out_i_type, bus.out_init, bus.out_alu_op,
                 bus.out_mem_ctrl, bus.out_trd_ctrl, bus.out_jmp_con, bus.out_wr, bus.out_rd_a,
                 bus.out_rd_b, bus.out_imm},
                {m_dec.wr_en, m_dec.wb_sel, m_dec.i_type, m_dec.init, m_dec.alu, m_dec.mem,
                 m_dec.tctl, m_dec.jc, m_ins[27:23], m_ins[22:18], m_ins[17:13], m_ins[15:0]});
         end

         c_acc     = bus.in_valid && c_rdy;
         c_flushed = m_valid && flush_mask[m_trd];
         if (wb_en) m_sb[wb_trd][wb_reg] = 1'b0;
         if (sq_en) m_sb[sq_trd][sq_reg] = 1'b0;
         if (c_flushed && m_dec.wr_en) m_sb[m_trd][m_ins[27:23]] = 1'b0;
         if (c_acc && c_d.init) begin
            m_sb[new_trd_id] = '0;
            for (int r = 0; r < NREG; r++) m_rf[new_trd_id][r] = '0;
         end
         if (c_acc && c_d.wr_en && c_wr != 0) m_sb[c_t][c_wr] = 1'b1;
         if (wb_en && wb_reg != 0 && !(c_acc && c_d.init && wb_trd == new_trd_id))
            m_rf[wb_trd][wb_reg] = wb_data;

         if (c_acc) begin
            m_valid = 1'b1;
            m_a = c_va; m_b = c_vb; m_pc = bus.pc; m_ins = bus.ins; m_trd = c_t;
            m_new = c_d.init ? new_trd_id : 3'd0;
            m_dec = c_d;
         end else if (m_valid && (bus.out_ready || c_flushed)) begin
            m_valid = 1'b0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      bus.in_valid = 0; bus.ins = '0; bus.pc = '0; bus.trd = '0; bus.out_ready = 1;
      new_trd_id = '0; flush_mask = '0;
      wb_en = 0; wb_trd = '0; wb_reg = '0; wb_data = '0;
      sq_en = 0; sq_trd = '0; sq_reg = '0;
   endtask

   task automatic issue(input logic [2:0] t, input logic [31:0] ins, input logic [31:0] pc);
      bus.in_valid = 1; bus.trd = t; bus.ins = ins; bus.pc = pc;
   endtask

   task automatic wb(input logic [2:0] t, input logic [4:0] r, input logic [31:0] d);
      wb_en = 1; wb_trd = t; wb_reg = r; wb_data = d;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      clr();
      rst_n = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_data_a", bus.out_data_a, 0);
      chk("rst_wr", bus.out_wr, 0);
      rst_n = 1;

      clr(); wb(0, 1, 5);   step();
      clr(); wb(0, 2, 7);   step();
      clr(); wb(1, 3, 99);  step();
      clr(); wb(5, 4, 44);  step();

      clr(); issue(0, mk(0, 3, 1, 2, 0), 32'h100); #1 chk("t1_ready", bus.in_ready, 1); step();
      chk("t1_valid", bus.out_valid, 1);
      chk("t1_data_a", bus.out_data_a, 5);
      chk("t1_data_b", bus.out_data_b, 7);
      chk("t1_wr", bus.out_wr, 3);

      clr(); issue(0, mk(0, 4, 3, 1, 0), 32'h104); #1;
      chk("t2_hazard", hazard, 1);
      chk("t2_ready", bus.in_ready, 0);
      step();
      chk("t2_empty", bus.out_valid, 0);
      clr(); issue(0, mk(0, 4, 3, 1, 0), 32'h104); wb(0, 3, 12); #1;
      chk("t2_bypass_haz", hazard, 0);
      step();
      chk("t2_bypass_a", bus.out_data_a, 12);
      chk("t2_bypass_b", bus.out_data_b, 5);

      clr(); issue(0, mk(1, 3, 1, 0, 13'h0007), 32'h108); step();
      clr(); issue(1, mk(0, 7, 3, 3, 0), 32'h200); #1 chk("t3_hazard", hazard, 0); step();
      chk("t3_data_a", bus.out_data_a, 99);
      chk("t3_trd", bus.out_trd, 1);

      clr(); issue(0, mk(0, 8, 1, 2, 13'd1), 32'h10c); step();
      for (int i = 0; i < 3; i++) begin
         clr(); bus.out_ready = 0; issue(2, mk(0, 1, 0, 0, 0), 32'h300); #1;
         chk("t4_stall_ready", bus.in_ready, 0);
         step();
         chk("t4_stall_pc", bus.out_pc, 32'h10c);
      end
      clr(); bus.out_ready = 0; flush_mask = 8'h01; step();
      chk("t4_flushed", bus.out_valid, 0);
      clr(); issue(0, mk(0, 9, 8, 0, 0), 32'h110); #1 chk("t4_sb_cleared", hazard, 0); step();
      clr(); flush_mask = 8'h01; issue(0, mk(0, 11, 1, 0, 0), 32'h114); #1;
      chk("t4_flush_refuse", bus.in_ready, 0);
      step();

      clr(); issue(0, mk(0, 12, 4, 0, 0), 32'h118); #1 chk("sq_pending", hazard, 1); step();
      clr(); issue(0, mk(0, 12, 4, 0, 0), 32'h118); sq_en = 1; sq_trd = 0; sq_reg = 4; step();
      clr(); issue(0, mk(0, 12, 4, 0, 0), 32'h118); #1 chk("sq_cleared", hazard, 0); step();

      clr(); wb(0, 0, 32'hdead); issue(0, mk(0, 13, 0, 1, 0), 32'h11c); step();
      chk("r0_bypass", bus.out_data_a, 0);
      clr(); issue(0, mk(0, 13, 0, 0, 0), 32'h120); step();
      chk("r0_write", bus.out_data_a, 0);

      clr(); issue(0, mk(1, 14, 1, 3, 0), 32'h124); #1 chk("itype_no_b", hazard, 0); step();
      clr(); issue(0, mk(3, 0, 1, 3, 0), 32'h128); #1 chk("store_b_haz", hazard, 1); step();

      clr(); issue(2, mk(1, 10, 0, 0, 0), 32'h500); wb(2, 10, 32'h55); step();
      clr(); issue(2, mk(0, 1, 10, 0, 0), 32'h504); #1 chk("set_wins", hazard, 1); step();
      clr(); issue(2, mk(0, 1, 10, 0, 0), 32'h504); wb(2, 10, 32'h66); step();
      chk("set_wins_data", bus.out_data_a, 32'h66);

      clr(); issue(3, mk(4, 0, 0, 0, 13'h5), 32'h600); #1 chk("jmp_flag", exp_jmp, 1); step();
      clr(); issue(3, mk(5, 0, 0, 0, 0), 32'h604); #1 chk("ret_flag", exp_return, 1); step();
      clr(); issue(3, mk(4'hf, 0, 0, 0, 0), 32'h608); #1 chk("inv_flag", invalid_op, 1); step();

      clr(); issue(5, mk(1, 6, 0, 0, 0), 32'h700); step();
      clr(); issue(0, mk(6, 0, 0, 0, 0), 32'h12c); new_trd_id = 5; wb(5, 4, 77); step();
      chk("t5_init", {bus.out_init, bus.out_new_trd}, {1'b1, 3'd5});
      clr(); issue(5, mk(0, 1, 4, 6, 0), 32'h704); #1 chk("t5_sb_clear", hazard, 0); step();
      chk("t5_rf_a", bus.out_data_a, 0);
      chk("t5_rf_b", bus.out_data_b, 0);

      for (int i = 0; i < NUM_TRD; i++) begin
         clr(); issue(3'(i), mk(1, 15, 0, 0, 13'(i)), 32'h800 + 32'(4 * i)); #1;
         chk("t6_ready", bus.in_ready, 1);
         step();
         chk("t6_trd", {bus.out_valid, bus.out_trd}, {1'b1, 3'(i)});
      end
      clr(); step();
      chk("t6_drain", bus.out_valid, 0);

      clr(); issue(0, mk(1, 16, 0, 0, 0), 32'h900); step();
      #2 rst_n = 0;
      #1 chk("async_rst", bus.out_valid, 0);
      @(posedge clk);
      #1 rst_n = 1;
      clr(); issue(0, mk(0, 17, 16, 1, 0), 32'h904); #1 chk("rst_sb", hazard, 0); step();
      chk("rst_rf", {bus.out_data_a, bus.out_data_b}, 64'd0);

      clr(); step(); step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
